reg_grp_tmo: RTL and testbench
==============================

Name: reg_grp_tmo

Overview:
- Parametrised register-group demultiplexer. Takes one upstream register request at a time and routes it to one of NUM_OUTPUTS downstream register slaves, using the top address bits as the slave select.
- Unlike a pass-through mux, it runs an explicit transaction FSM:
  - holds the downstream request until that slave acks;
  - enforces a per-transaction timeout;
  - answers out-of-range selects itself;
  - keeps a saturating timeout counter.
- Sits between the CPCI register bus decoder and module register blocks, so a hung slave cannot stall the bus.

Parameters:
- REG_ADDR_BITS, 10, upstream address width.
- NUM_OUTPUTS, 4, number of downstream slaves. Must be ≥2; need not be a power of 2.
- DATA_WIDTH, 32, register data width.
- TIMEOUT_CYCLES, 64, cycles in WAIT before the block aborts. Must be ≥2.
- BAD_SEL_DATA, 32'hDEAD_BEEF, read data returned for an out-of-range select.
- TIMEOUT_DATA, 32'hDEAD_0001, read data returned on timeout.
- SEL_BITS (localparam), ceil(log2(NUM_OUTPUTS)).
- LADDR_BITS (localparam), REG_ADDR_BITS-SEL_BITS.

Ports:
- clk, in, 1, clock.
- reset, in, 1, synchronous, active-high.
- reg_req, in, 1, upstream request. Held high until reg_ack.
- reg_rd_wr_L, in, 1, 1=read, 0=write.
- reg_addr, in, REG_ADDR_BITS, upstream address. Slave select = [REG_ADDR_BITS-1 -: SEL_BITS].
- reg_wr_data, in, DATA_WIDTH, write data.
- reg_ack, out, 1, single-cycle completion pulse.
- reg_rd_data, out, DATA_WIDTH, read data. Valid while reg_ack=1.
- local_reg_req, out, NUM_OUTPUTS, per-slave request (one-hot or zero).
- local_reg_rd_wr_L, out, NUM_OUTPUTS, per-slave rd/wr.
- local_reg_addr, out, NUM_OUTPUTS*LADDR_BITS, per-slave address. Slave j occupies slice [j*LADDR_BITS +: LADDR_BITS].
- local_reg_wr_data, out, NUM_OUTPUTS*DATA_WIDTH, per-slave write data.
- local_reg_ack, in, NUM_OUTPUTS, per-slave ack.
- local_reg_rd_data, in, NUM_OUTPUTS*DATA_WIDTH, per-slave read data.
- timeout_count, out, 16, saturating count of timed-out transactions.
- busy, out, 1, high in any state other than IDLE.

Behaviour:
- Reset, synchronous:
  - state=IDLE.
  - All local_* outputs 0; reg_ack=0; reg_rd_data=0; timeout_count=0; timer=0.
  - Reset mid-transaction drops local_reg_req on the same edge; no ack is generated.
- Non-selected slaves always see req/rd_wr_L/addr/wr_data = 0.
- IDLE:
  - On an edge with reg_req=1: latch sel, lower address, rd_wr_L and wr_data.
  - If sel < NUM_OUTPUTS: on that same edge, local_reg_req[sel] goes to 1 with latched fields. Clear the timer and go to WAIT.
  - Else (sel ≥ NUM_OUTPUTS): set reg_ack=1 and reg_rd_data=BAD_SEL_DATA. Go to DONE. Latency: ack appears in the cycle after req is first sampled.
- WAIT:
  - local_reg_req[sel] and its fields are held constant. Timer increments each cycle.
  - If local_reg_ack[sel]=1: on that edge drop local_reg_req, set reg_ack=1 and reg_rd_data=local_reg_rd_data[sel] (captured even for writes). Go to DONE.
  - Else if timer==TIMEOUT_CYCLES-1: drop local_reg_req, set reg_ack=1 and reg_rd_data=TIMEOUT_DATA. Increment timeout_count, saturating at 16'hFFFF. Go to DONE.
  - Simultaneous ack and timeout on the same edge: the ack wins and the count is not incremented.
  - Acks from non-selected slaves are ignored.
- DONE:
  - reg_ack is cleared on the first edge in DONE, so it is exactly one cycle wide. reg_rd_data holds its value.
  - Stay in DONE until reg_req=0 is sampled, then go to IDLE. This prevents a held request from retriggering.
  - Any downstream ack still high in DONE is ignored.
- Minimum latency: reg_req sampled at edge 0, slave acks combinationally in its first request cycle, reg_ack high after edge 1.
- busy = (state != IDLE).

Test Plan:
- Read of slave 2 (NUM_OUTPUTS=4, addr=10'h2A5): local_reg_req=4'b0100 and local_reg_addr slice 2 = 8'hA5. Slave acks 3 cycles later with 32'h1234_5678 → reg_ack pulses 1 cycle with rd_data=32'h1234_5678; local_reg_req returns to 0 on the ack edge.
- Write to slave 0 (wr_data=32'hCAFE_F00D): slave 0 sees the data while the other slaves see 0. After ack → reg_ack single pulse; reg_req held 5 extra cycles produces no second downstream request.
- NUM_OUTPUTS=3, addr select=3 → no local_reg_req ever asserted; reg_ack one cycle after req with rd_data=32'hDEAD_BEEF.
- Slave 1 never acks, TIMEOUT_CYCLES=64 → local_reg_req[1] high for exactly 64 cycles, then reg_ack with rd_data=32'hDEAD_0001 and timeout_count=1. A second timeout gives count=2. A late ack from slave 1 after the abort is ignored.
- Ack arrives on cycle 64 (the timeout edge) → normal completion with slave data; timeout_count unchanged.
- Reset asserted in WAIT → next cycle all local_reg_req=0, reg_ack=0, busy=0. A new request after reset completes normally.

Source files
------------

// File: rtl/reg_grp_tmo.sv
// Register-group demultiplexer: routes one upstream register request to one of
// NUM_OUTPUTS slaves, with a per-transaction timeout and out-of-range handling.
module reg_grp_tmo #(
  parameter int          REG_ADDR_BITS  = 10,
  parameter int          NUM_OUTPUTS    = 4,
  parameter int          DATA_WIDTH     = 32,
  parameter int          TIMEOUT_CYCLES = 64,
  parameter logic [31:0] BAD_SEL_DATA   = 32'hDEAD_BEEF,
  parameter logic [31:0] TIMEOUT_DATA   = 32'hDEAD_0001,
  localparam int         SEL_BITS       = $clog2(NUM_OUTPUTS),
  localparam int         LADDR_BITS     = REG_ADDR_BITS - SEL_BITS
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              reg_req,
  input  logic                              reg_rd_wr_L,
  input  logic [REG_ADDR_BITS-1:0]          reg_addr,
  input  logic [DATA_WIDTH-1:0]             reg_wr_data,
  output logic                              reg_ack,
  output logic [DATA_WIDTH-1:0]             reg_rd_data,
  output logic [NUM_OUTPUTS-1:0]            local_reg_req,
  output logic [NUM_OUTPUTS-1:0]            local_reg_rd_wr_L,
  output logic [NUM_OUTPUTS*LADDR_BITS-1:0] local_reg_addr,
  output logic [NUM_OUTPUTS*DATA_WIDTH-1:0] local_reg_wr_data,
  input  logic [NUM_OUTPUTS-1:0]            local_reg_ack,
  input  logic [NUM_OUTPUTS*DATA_WIDTH-1:0] local_reg_rd_data,
  output logic [15:0]                       timeout_count,
  output logic                              busy
);

  localparam int TMR_BITS = $clog2(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t                  state, state_nxt;
  logic [SEL_BITS-1:0]     sel_q;
  logic [LADDR_BITS-1:0]   laddr_q;
  logic                    rd_wr_q;
  logic [DATA_WIDTH-1:0]   wr_data_q;
  logic                    req_active;
  logic [TMR_BITS-1:0]     timer;

  logic [SEL_BITS-1:0]     sel_in;
  logic                    in_range;
  logic                    slave_ack;
  logic [DATA_WIDTH-1:0]   slave_rd_data;
  logic                    timed_out;

  assign sel_in    = reg_addr[REG_ADDR_BITS-1 -: SEL_BITS];
  assign in_range  = {1'b0, sel_in} < (SEL_BITS+1)'(NUM_OUTPUTS);
  assign timed_out = (timer == TMR_BITS'(TIMEOUT_CYCLES - 1));

  // Only the latched slave's ack/data matter; everyone else is ignored.
  always_comb begin
    slave_ack     = 1'b0;
    slave_rd_data = '0;
    for (int j = 0; j < NUM_OUTPUTS; j++) begin
      if (sel_q == SEL_BITS'(j)) begin
        slave_ack     = local_reg_ack[j];
        slave_rd_data = local_reg_rd_data[j*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // NOTE: every always_comb output gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (reg_req) state_nxt = in_range ? WAIT : DONE;
      WAIT: if (slave_ack || timed_out) state_nxt = DONE;
      DONE: if (!reg_req) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy              = (state != IDLE);
    local_reg_req     = '0;
    local_reg_rd_wr_L = '0;
    local_reg_addr    = '0;
    local_reg_wr_data = '0;
    for (int j = 0; j < NUM_OUTPUTS; j++) begin
      if (req_active && sel_q == SEL_BITS'(j)) begin
        local_reg_req[j]                               = 1'b1;
        local_reg_rd_wr_L[j]                           = rd_wr_q;
        local_reg_addr[j*LADDR_BITS +: LADDR_BITS]     = laddr_q;
        local_reg_wr_data[j*DATA_WIDTH +: DATA_WIDTH]  = wr_data_q;
      end
    end
  end

  // NOTE: registered state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      sel_q         <= '0;
      laddr_q       <= '0;
      rd_wr_q       <= 1'b0;
      wr_data_q     <= '0;
      req_active    <= 1'b0;
      timer         <= '0;
      reg_ack       <= 1'b0;
      reg_rd_data   <= '0;
      timeout_count <= '0;
    end else begin
      reg_ack <= 1'b0;
      case (state)
        IDLE: if (reg_req) begin
          sel_q     <= sel_in;
          laddr_q   <= reg_addr[LADDR_BITS-1:0];
          rd_wr_q   <= reg_rd_wr_L;
          wr_data_q <= reg_wr_data;
          timer     <= '0;
          if (in_range) begin
            req_active <= 1'b1;
          end else begin
            reg_ack     <= 1'b1;
            reg_rd_data <= BAD_SEL_DATA[DATA_WIDTH-1:0];
          end
        end
        WAIT: begin
          timer <= timer + 1'b1;
          // Ack beats timeout when both land on the same edge.
          if (slave_ack) begin
            req_active  <= 1'b0;
            reg_ack     <= 1'b1;
            reg_rd_data <= slave_rd_data;
          end else if (timed_out) begin
            req_active  <= 1'b0;
            reg_ack     <= 1'b1;
            reg_rd_data <= TIMEOUT_DATA[DATA_WIDTH-1:0];
            if (timeout_count != 16'hFFFF) timeout_count <= timeout_count + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_grp_tmo.sv
// Self-checking bench for reg_grp_tmo: table-driven transactions with a
// read-data scoreboard, plus sequences for bad select and mid-transaction reset.
module tb_reg_grp_tmo;

  localparam int TMO = 64;

  logic         clk = 1'b0;
  logic         reset;
  logic         reg_req, reg_req3;
  logic         reg_rd_wr_L;
  logic [9:0]   reg_addr;
  logic [31:0]  reg_wr_data;

  logic         reg_ack;
  logic [31:0]  reg_rd_data;
  logic [3:0]   local_reg_req, local_reg_rd_wr_L;
  logic [31:0]  local_reg_addr;
  logic [127:0] local_reg_wr_data;
  logic [3:0]   local_reg_ack;
  logic [127:0] local_reg_rd_data;
  logic [15:0]  timeout_count;
  logic         busy;

  logic         reg_ack3;
  logic [31:0]  reg_rd_data3;
  logic [2:0]   local_reg_req3, local_reg_rd_wr_L3;
  logic [23:0]  local_reg_addr3;
  logic [95:0]  local_reg_wr_data3;
  logic [15:0]  timeout_count3;
  logic         busy3;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];
  logic prev_ack = 1'b0;

  always #5 clk = ~clk;

  reg_grp_tmo #(.NUM_OUTPUTS(4), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset(reset), .reg_req(reg_req), .reg_rd_wr_L(reg_rd_wr_L),
    .reg_addr(reg_addr), .reg_wr_data(reg_wr_data), .reg_ack(reg_ack),
    .reg_rd_data(reg_rd_data), .local_reg_req(local_reg_req),
    .local_reg_rd_wr_L(local_reg_rd_wr_L), .local_reg_addr(local_reg_addr),
    .local_reg_wr_data(local_reg_wr_data), .local_reg_ack(local_reg_ack),
    .local_reg_rd_data(local_reg_rd_data), .timeout_count(timeout_count),
    .busy(busy)
  );

  reg_grp_tmo #(.NUM_OUTPUTS(3), .TIMEOUT_CYCLES(TMO)) dut3 (
    .clk(clk), .reset(reset), .reg_req(reg_req3), .reg_rd_wr_L(reg_rd_wr_L),
    .reg_addr(reg_addr), .reg_wr_data(reg_wr_data), .reg_ack(reg_ack3),
    .reg_rd_data(reg_rd_data3), .local_reg_req(local_reg_req3),
    .local_reg_rd_wr_L(local_reg_rd_wr_L3), .local_reg_addr(local_reg_addr3),
    .local_reg_wr_data(local_reg_wr_data3), .local_reg_ack(3'b000),
    .local_reg_rd_data(96'd0), .timeout_count(timeout_count3), .busy(busy3)
  );

  typedef struct {
    logic [1:0]  sel;
    logic [7:0]  laddr;
    logic        rd_wr_L;
    logic [31:0] wr_data;
    int          ack_delay;   // -1: slave never acks
    logic [31:0] slave_data;
    int          hold;        // extra cycles reg_req stays high after ack
    bit          noise;       // other slaves ack while waiting
    bit          late_ack;    // selected slave acks during hold
    logic [31:0] exp_rd;
    logic [15:0] exp_cnt;
  } vec_t;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard: every reg_ack pops one expected read-data value.
  always @(negedge clk) begin
    if (reg_ack) begin
      check("ack_single_cycle", prev_ack, 1'b0);
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_ack: rd_data %0h with nothing expected", reg_rd_data);
      end else begin
        check("sb_rd_data", reg_rd_data, exp_q.pop_front());
      end
    end
    prev_ack = reg_ack;
  end

  task automatic do_txn(input vec_t v);
    logic [3:0] oh;
    int n;
    bit held, quiet;
    oh = 4'b0001 << v.sel;
    @(negedge clk);
    reg_addr    = {v.sel, v.laddr};
    reg_rd_wr_L = v.rd_wr_L;
    reg_wr_data = v.wr_data;
    reg_req     = 1'b1;
    exp_q.push_back(v.exp_rd);
    if (v.noise) local_reg_ack = ~oh;
    @(negedge clk);
    check("req_onehot", local_reg_req, oh);
    check("addr_demux", local_reg_addr, 32'(v.laddr) << (8 * v.sel));
    check("wdata_demux", local_reg_wr_data, 128'(v.wr_data) << (32 * v.sel));
    check("rdwr_demux", local_reg_rd_wr_L, v.rd_wr_L ? oh : 4'b0000);
    check("busy_wait", busy, 1'b1);
    if (v.ack_delay >= 0) begin
      held = 1'b1;
      repeat (v.ack_delay) begin
        @(negedge clk);
        if (local_reg_req !== oh || reg_ack !== 1'b0) held = 1'b0;
      end
      check("req_held_until_ack", held, 1'b1);
      local_reg_ack     = oh;
      local_reg_rd_data = 128'(v.slave_data) << (32 * v.sel);
      @(negedge clk);
    end else begin
      n = 0;
      while (local_reg_req[v.sel] && n < 200) begin
        n++;
        @(negedge clk);
      end
      check("req_cycles_to_timeout", n, TMO);
    end
    check("ack_seen", reg_ack, 1'b1);
    check("req_dropped", local_reg_req, 4'b0000);
    check("tmo_count", timeout_count, v.exp_cnt);
    local_reg_ack = v.late_ack ? oh : 4'b0000;
    quiet = 1'b1;
    repeat (v.hold) begin
      @(negedge clk);
      if (local_reg_req !== 4'b0000 || reg_ack !== 1'b0 || busy !== 1'b1) quiet = 1'b0;
    end
    if (v.hold > 0) check("held_req_quiet", quiet, 1'b1);
    reg_req       = 1'b0;
    local_reg_ack = 4'b0000;
    @(negedge clk);
    check("idle_after_drop", busy, 1'b0);
    check("rd_data_holds", reg_rd_data, v.exp_rd);
    check("tmo_count_final", timeout_count, v.exp_cnt);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[7];
    reset = 1'b1; reg_req = 1'b0; reg_req3 = 1'b0; reg_rd_wr_L = 1'b0;
    reg_addr = '0; reg_wr_data = '0; local_reg_ack = '0; local_reg_rd_data = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_ack", reg_ack, 1'b0);
    check("rst_rd_data", reg_rd_data, 32'h0);
    check("rst_local_req", local_reg_req, 4'b0000);
    check("rst_local_addr", local_reg_addr, 32'h0);
    check("rst_tmo_count", timeout_count, 16'h0);
    check("rst_busy", busy, 1'b0);

    //        sel   laddr  rd  wr_data        dly  slave_data     hold noise late exp_rd         cnt
    tbl[0] = '{2'd2, 8'hA5, 1, 32'h0,          3,  32'h1234_5678, 0,   1,    0,   32'h1234_5678, 16'd0};
    tbl[1] = '{2'd0, 8'h3C, 0, 32'hCAFE_F00D,  1,  32'h0000_0055, 5,   0,    0,   32'h0000_0055, 16'd0};
    tbl[2] = '{2'd3, 8'hFF, 1, 32'h0,          0,  32'hA5A5_5A5A, 0,   0,    0,   32'hA5A5_5A5A, 16'd0};
    tbl[3] = '{2'd1, 8'h10, 1, 32'h0,          -1, 32'h0,         0,   0,    0,   32'hDEAD_0001, 16'd1};
    tbl[4] = '{2'd1, 8'h11, 0, 32'h5555_AAAA,  -1, 32'h0,         3,   0,    1,   32'hDEAD_0001, 16'd2};
    tbl[5] = '{2'd1, 8'h12, 1, 32'h0,          63, 32'h7777_0001, 0,   0,    0,   32'h7777_0001, 16'd2};
    tbl[6] = '{2'd0, 8'h01, 1, 32'h0,          62, 32'h0BAD_CAFE, 0,   0,    0,   32'h0BAD_CAFE, 16'd2};
    for (int i = 0; i < 7; i++) do_txn(tbl[i]);

    // Out-of-range select on the three-slave instance.
    @(negedge clk);
    reg_addr = {2'd3, 8'h12};
    reg_req3 = 1'b1;
    @(negedge clk);
    check("badsel_ack", reg_ack3, 1'b1);
    check("badsel_rd_data", reg_rd_data3, 32'hDEAD_BEEF);
    check("badsel_no_req", local_reg_req3, 3'b000);
    @(negedge clk);
    check("badsel_ack_cleared", reg_ack3, 1'b0);
    check("badsel_data_holds", reg_rd_data3, 32'hDEAD_BEEF);
    repeat (2) @(negedge clk);
    check("badsel_no_retrigger", {reg_ack3, local_reg_req3, busy3}, 5'b0_000_1);
    reg_req3 = 1'b0;
    @(negedge clk);
    check("badsel_idle", busy3, 1'b0);

    // Reset in the middle of a WAIT.
    reg_addr = {2'd3, 8'h11};
    reg_rd_wr_L = 1'b1;
    reg_req  = 1'b1;
    repeat (5) @(negedge clk);
    check("pre_reset_req", local_reg_req, 4'b1000);
    reset   = 1'b1;
    reg_req = 1'b0;
    @(negedge clk);
    check("reset_drop_req", local_reg_req, 4'b0000);
    check("reset_no_ack", reg_ack, 1'b0);
    check("reset_busy", busy, 1'b0);
    check("reset_tmo_count", timeout_count, 16'h0);
    reset = 1'b0;
    do_txn('{2'd2, 8'h44, 1, 32'h0, 2, 32'h600D_0001, 0, 0, 0, 32'h600D_0001, 16'd0});

    repeat (2) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
